// File: rtl/alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : alu_iter
// Brief    : Handshaked integer ALU with flags and iterative MUL/MULHU/DIVU/REMU
// Revision : 1.0
// ============================================================================
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             dz,
    output logic             ill
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_INIT = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     b_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [SHW-1:0]       cnt_q;
    logic [WIDTH-1:0]     result_q;
    logic                 cout_q, ovf_q, zero_q, dz_q, ill_q;

    logic [WIDTH:0]       w_sum, w_diff;
    logic [SHW-1:0]       w_shamt;
    logic [WIDTH-1:0]     w_res;
    logic                 w_cout, w_ovf, w_ill, w_iter;

    assign w_sum   = {1'b0, a} + {1'b0, b};
    assign w_diff  = {1'b0, a} - {1'b0, b};
    assign w_shamt = b[SHW-1:0];

    always_comb begin
        w_res  = '0;
        w_cout = 1'b0;
        w_ovf  = 1'b0;
        w_ill  = 1'b0;
        w_iter = 1'b0;
        case (op)
            4'd0: begin
                w_res  = w_sum[WIDTH-1:0];
                w_cout = w_sum[WIDTH];
                w_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1: begin
                w_res  = w_diff[WIDTH-1:0];
                w_cout = w_diff[WIDTH];
                w_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2:  w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd3:  w_res = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd4:  w_res = a & b;
            4'd5:  w_res = a | b;
            4'd6:  w_res = a ^ b;
            4'd7:  w_res = a << w_shamt;
            4'd8:  w_res = a >> w_shamt;
            4'd9:  w_res = $unsigned($signed(a) >>> w_shamt);
            4'd10, 4'd11, 4'd12, 4'd13: w_iter = 1'b1;
            default: w_ill = 1'b1;
        endcase
    end

    // acc_q holds {high, low}: product accumulator for MUL, {remainder, quotient} for DIV
    logic [WIDTH:0]       w_mul_sum, w_div_trial, w_div_rem;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_mul_acc, w_div_acc, w_iter_acc;
    logic [WIDTH-1:0]     w_iter_res;

    assign w_mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign w_mul_acc   = {w_mul_sum, acc_q[WIDTH-1:1]};
    assign w_div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign w_div_ge    = (w_div_trial >= {1'b0, b_q});
    assign w_div_rem   = w_div_ge ? (w_div_trial - {1'b0, b_q}) : w_div_trial;
    assign w_div_acc   = {w_div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], w_div_ge};
    assign w_iter_acc  = op_q[2] ? w_div_acc : w_mul_acc;
    // MULHU and REMU take the upper half
    assign w_iter_res  = op_q[0] ? w_iter_acc[2*WIDTH-1:WIDTH] : w_iter_acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = w_iter ? S_BUSY : S_DONE;
            S_BUSY: if (cnt_q == '0) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid) begin
                    op_q  <= op;
                    b_q   <= b;
                    acc_q <= {{WIDTH{1'b0}}, a};
                    cnt_q <= CNT_INIT;
                    if (!w_iter) begin
                        result_q <= w_res;
                        cout_q   <= w_cout;
                        ovf_q    <= w_ovf;
                        zero_q   <= (w_res == '0);
                        dz_q     <= 1'b0;
                        ill_q    <= w_ill;
                    end
                end
                S_BUSY: begin
                    acc_q <= w_iter_acc;
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == '0) begin
                        result_q <= w_iter_res;
                        cout_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= (w_iter_res == '0);
                        dz_q     <= op_q[2] && (b_q == '0);
                        ill_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign dz        = dz_q;
    assign ill       = ill_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_iter
// Brief    : Scoreboard bench for alu_iter at WIDTH=32 and WIDTH=8
// Revision : 1.0
// ============================================================================
module tb_alu_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] res;
        logic        co, ov, z, dz, il;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    logic        rst32, iv32, ir32, ov32, or32, co32, ovf32, z32, dz32, il32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, res32;
    logic        rst8, iv8, ir8, ov8, or8, co8, ovf8, z8, dz8, il8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, res8;
    logic        prev32, prev8;

    alu_iter #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32), .op(op32),
        .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32), .result(res32),
        .cout(co32), .ovf(ovf32), .zero(z32), .dz(dz32), .ill(il32)
    );

    alu_iter #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .op(op8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8), .result(res8),
        .cout(co8), .ovf(ovf8), .zero(z8), .dz(dz8), .ill(il8)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input bit u, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         input bit push, input logic [63:0] r, input logic co, input logic ov,
                         input logic z, input logic dz, input logic il, input int lat);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!(u ? ir8 : ir32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("issue_timeout", u ? ir8 : ir32, 1);
        if (u) begin iv8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
        else   begin iv32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
        if (push) begin
            e.res = r; e.co = co; e.ov = ov; e.z = z; e.dz = dz; e.il = il;
            e.lat = lat; e.acc = cyc + 1;
            if (u) q8.push_back(e);
            else   q32.push_back(e);
        end
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        iv8  = 1'b0;
    endtask

    task automatic drain(input bit u);
        int n = 0;
        while ((u ? q8.size() : q32.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", u ? ov8 : ov32, 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst32) prev32 <= 1'b0;
        else begin
            if (ov32 && !prev32) begin
                if (q32.size() == 0) chk("spurious_valid32", ov32, 0);
                else chk("latency32", cyc - q32[0].acc + 1, q32[0].lat);
            end
            if (ov32 && q32.size() != 0) begin
                chk("result32", {32'd0, res32}, q32[0].res);
                if (or32) begin
                    chk("cout32", co32, q32[0].co);
                    chk("ovf32",  ovf32, q32[0].ov);
                    chk("zero32", z32, q32[0].z);
                    chk("dz32",   dz32, q32[0].dz);
                    chk("ill32",  il32, q32[0].il);
                    void'(q32.pop_front());
                end
            end else if (q32.size() != 0 && cyc >= q32[0].acc) begin
                chk("in_ready_busy32", ir32, 0);
            end
            prev32 <= ov32;
        end
    end

    always @(negedge clk) begin
        if (rst8) prev8 <= 1'b0;
        else begin
            if (ov8 && !prev8) begin
                if (q8.size() == 0) chk("spurious_valid8", ov8, 0);
                else chk("latency8", cyc - q8[0].acc + 1, q8[0].lat);
            end
            if (ov8 && q8.size() != 0) begin
                chk("result8", {56'd0, res8}, q8[0].res);
                if (or8) begin
                    chk("cout8", co8, q8[0].co);
                    chk("ovf8",  ovf8, q8[0].ov);
                    chk("zero8", z8, q8[0].z);
                    chk("dz8",   dz8, q8[0].dz);
                    chk("ill8",  il8, q8[0].il);
                    void'(q8.pop_front());
                end
            end else if (q8.size() != 0 && cyc >= q8[0].acc) begin
                chk("in_ready_busy8", ir8, 0);
            end
            prev8 <= ov8;
        end
    end

    initial begin
        int n;
        int seen;
        rst32 = 1'b1; iv32 = 1'b0; or32 = 1'b1; op32 = '0; a32 = '0; b32 = '0;
        rst8  = 1'b1; iv8  = 1'b0; or8  = 1'b1; op8  = '0; a8  = '0; b8  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst32 = 1'b0;
        rst8  = 1'b0;
        @(negedge clk);
        chk("rst_in_ready",  ir32, 1);
        chk("rst_out_valid", ov32, 0);
        chk("rst_result",    res32, 0);
        chk("rst_flags",     {co32, ovf32, z32, dz32, il32}, 0);
        chk("rst_in_ready8", ir8, 1);

        //    u  op     a             b            push res            co ov z  dz il lat
        issue(0, 4'd0,  64'hFFFFFFFF, 64'h1,       1, 64'h0,         1, 0, 1, 0, 0, 1);
        issue(0, 4'd0,  64'h7FFFFFFF, 64'h1,       1, 64'h80000000,  0, 1, 0, 0, 0, 1);
        issue(0, 4'd1,  64'h0,        64'h1,       1, 64'hFFFFFFFF,  1, 0, 0, 0, 0, 1);
        issue(0, 4'd2,  64'h80000000, 64'h7FFFFFFF,1, 64'h1,         0, 0, 0, 0, 0, 1);
        issue(0, 4'd3,  64'h80000000, 64'h7FFFFFFF,1, 64'h0,         0, 0, 1, 0, 0, 1);
        issue(0, 4'd9,  64'h80000000, 64'h3F,      1, 64'hFFFFFFFF,  0, 0, 0, 0, 0, 1);
        issue(0, 4'd7,  64'h1,        64'h21,      1, 64'h2,         0, 0, 0, 0, 0, 1);
        issue(0, 4'd10, 64'hFFFFFFFF, 64'h2,       1, 64'hFFFFFFFE,  0, 0, 0, 0, 0, 33);
        issue(0, 4'd11, 64'hFFFFFFFF, 64'h2,       1, 64'h1,         0, 0, 0, 0, 0, 33);
        issue(0, 4'd12, 64'd100,      64'd7,       1, 64'd14,        0, 0, 0, 0, 0, 33);
        issue(0, 4'd13, 64'd100,      64'd7,       1, 64'd2,         0, 0, 0, 0, 0, 33);
        issue(0, 4'd12, 64'd5,        64'd0,       1, 64'hFFFFFFFF,  0, 0, 0, 1, 0, 33);
        issue(0, 4'd13, 64'd5,        64'd0,       1, 64'd5,         0, 0, 0, 1, 0, 33);
        issue(0, 4'd15, 64'h1234,     64'h5678,    1, 64'h0,         0, 0, 1, 0, 1, 1);
        drain(0);

        // Hold the result for 10 cycles while a second request is pending
        or32 = 1'b0;
        issue(0, 4'd12, 64'd100, 64'd7, 1, 64'd14, 0, 0, 0, 0, 0, 33);
        iv32 = 1'b1; op32 = 4'd0; a32 = 32'd1; b32 = 32'd1;
        n = 0;
        while (!ov32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_valid_seen", ov32, 1);
        repeat (10) begin
            @(negedge clk);
            chk("hold_no_accept", ir32, 0);
            chk("hold_valid", ov32, 1);
        end
        @(posedge clk);
        #1;
        iv32 = 1'b0;
        or32 = 1'b1;
        drain(0);

        // Abort a DIVU with reset partway through
        issue(0, 4'd12, 64'd1000, 64'd3, 0, 64'd0, 0, 0, 0, 0, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        rst32 = 1'b1;
        @(posedge clk);
        #1;
        rst32 = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", ov32, 0);
        chk("abort_in_ready",  ir32, 1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (ov32) seen++;
        end
        chk("abort_no_valid", seen, 0);
        issue(0, 4'd0, 64'd2, 64'd3, 1, 64'd5, 0, 0, 0, 0, 0, 1);
        drain(0);

        issue(1, 4'd0,  64'hFF,  64'h1, 1, 64'h0,  1, 0, 1, 0, 0, 1);
        issue(1, 4'd9,  64'h80,  64'h7, 1, 64'hFF, 0, 0, 0, 0, 0, 1);
        issue(1, 4'd12, 64'd100, 64'd7, 1, 64'd14, 0, 0, 0, 0, 0, 9);
        issue(1, 4'd13, 64'd100, 64'd7, 1, 64'd2,  0, 0, 0, 0, 0, 9);
        issue(1, 4'd12, 64'd5,   64'd0, 1, 64'hFF, 0, 0, 0, 1, 0, 9);
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
